// File: rtl/imem_loader_if.sv
// Host word stream plus Avalon-MM master bus between the instruction-memory loader and its environment.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic                  s_valid;
  logic [DATA_W-1:0]     s_data;
  logic                  s_ready;
  logic [ADDR_W+1:0]     avm_address;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic                  avm_read;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_waitrequest;
  logic                  avm_readdatavalid;

  modport master (
    input  s_valid, s_data, avm_readdata, avm_waitrequest, avm_readdatavalid,
    output s_ready, avm_address, avm_byteenable, avm_write, avm_writedata, avm_read
  );

  modport slave (
    output s_valid, s_data, avm_readdata, avm_waitrequest, avm_readdatavalid,
    input  s_ready, avm_address, avm_byteenable, avm_write, avm_writedata, avm_read
  );
endinterface

// File: rtl/imem_loader_master.sv
// Fills instruction memory from a host word stream, reads it back, and checks the
// readback sum against the written sum while holding the CPU in reset.
module imem_loader_master #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 5120,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_word_count,
  imem_loader_if.master     bus,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [31:0]       o_checksum
);
  localparam int unsigned BA_W  = ADDR_W + 2;
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SUM_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_WRITE, S_RD_REQ, S_RD_WAIT, S_PASS, S_FAIL
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, r_word_count;
  logic [SUM_W-1:0]  r_wsum, r_rsum, r_checksum;
  logic [BA_W-1:0]   r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_s_ready, r_write, r_read, r_busy, r_done, r_error;

  logic              w_bad_count, w_last, w_sum_match, w_take;
  logic              w_s_ready_nxt, w_write_nxt, w_read_nxt, w_busy_nxt;
  logic [SUM_W-1:0]  w_rsum_nxt;
  logic [ADDR_W-1:0] w_base, w_idx_inc, w_word_cur, w_word_inc;

  assign w_bad_count = (i_word_count == '0) ||
                       ((BASE_WORD + 32'(i_word_count)) > DEPTH);
  assign w_last      = (r_idx == (r_word_count - ADDR_W'(1)));
  assign w_rsum_nxt  = r_rsum + SUM_W'(bus.avm_readdata);
  assign w_sum_match = (w_rsum_nxt == r_wsum);
  assign w_take      = bus.s_valid && r_s_ready;
  assign w_base      = ADDR_W'(BASE_WORD);
  assign w_idx_inc   = r_idx + ADDR_W'(1);
  assign w_word_cur  = w_base + r_idx;
  assign w_word_inc  = w_base + w_idx_inc;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and next values of the state-decoded outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_s_ready_nxt = 1'b0;
    w_write_nxt   = 1'b0;
    w_read_nxt    = 1'b0;
    w_busy_nxt    = 1'b0;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = w_bad_count ? S_FAIL : S_ACCEPT;
      S_ACCEPT:  if (w_take) w_state_nxt = S_WRITE;
      S_WRITE:   if (!bus.avm_waitrequest) w_state_nxt = w_last ? S_RD_REQ : S_ACCEPT;
      S_RD_REQ:  if (!bus.avm_waitrequest) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.avm_readdatavalid) begin
          if (w_last) w_state_nxt = w_sum_match ? S_PASS : S_FAIL;
          else        w_state_nxt = S_RD_REQ;
        end
      end
      S_PASS, S_FAIL: w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
    w_s_ready_nxt = (w_state_nxt == S_ACCEPT);
    w_write_nxt   = (w_state_nxt == S_WRITE);
    w_read_nxt    = (w_state_nxt == S_RD_REQ);
    w_busy_nxt    = (w_state_nxt == S_ACCEPT) || (w_state_nxt == S_WRITE) ||
                    (w_state_nxt == S_RD_REQ) || (w_state_nxt == S_RD_WAIT);
  end

  // Datapath, sums and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx        <= '0;
      r_word_count <= '0;
      r_wsum       <= '0;
      r_rsum       <= '0;
      r_checksum   <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_s_ready    <= 1'b0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_write   <= w_write_nxt;
      r_read    <= w_read_nxt;
      r_busy    <= w_busy_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx        <= '0;
            r_word_count <= i_word_count;
            r_wsum       <= '0;
            r_rsum       <= '0;
            r_checksum   <= '0;
            r_done       <= 1'b0;
            r_error      <= w_bad_count;
          end
        end
        S_ACCEPT: begin
          if (w_take) begin
            r_wdata <= bus.s_data;
            r_addr  <= {w_word_cur, 2'b00};
            r_wsum  <= r_wsum + SUM_W'(bus.s_data);
          end
        end
        S_WRITE: begin
          if (!bus.avm_waitrequest) begin
            if (w_last) begin
              r_idx  <= '0;
              r_addr <= {w_base, 2'b00};
            end else begin
              r_idx  <= w_idx_inc;
            end
          end
        end
        S_RD_WAIT: begin
          // Readback is judged by its sum; individual words are not buffered
          if (bus.avm_readdatavalid) begin
            r_rsum <= w_rsum_nxt;
            if (w_last) begin
              r_done     <= w_sum_match;
              r_error    <= !w_sum_match;
              r_checksum <= r_wsum;
            end else begin
              r_idx  <= w_idx_inc;
              r_addr <= {w_word_inc, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready        = r_s_ready;
  assign bus.avm_address    = r_addr;
  assign bus.avm_byteenable = {BE_W{1'b1}};
  assign bus.avm_write      = r_write;
  assign bus.avm_writedata  = r_wdata;
  assign bus.avm_read       = r_read;
  assign o_busy             = r_busy;
  assign o_cpu_hold         = r_busy;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_checksum         = r_checksum;
endmodule

// File: tb/tb_imem_loader_master.sv
// Bench for imem_loader_master: stream driver, Avalon memory model with stalls and
// corruption, and a write/read scoreboard of expected addresses and data.
module tb_imem_loader_master;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 5120;

  typedef struct packed {
    logic [ADDR_W+1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              busy, cpu_hold, done, error;
  logic [31:0]       checksum;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_WORD(0)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_word_count(word_count), .bus(bus),
    .o_busy(busy), .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error), .o_checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  wr_t               wq[$];
  logic [ADDR_W+1:0] rq[$];
  logic [31:0]       src[$];
  logic [31:0]       mem [DEPTH];
  int                wr_cnt, rd_cnt, req_cnt, both_err, hold_err, hold_drop, stall;
  bit                stall_en, corrupt_en, track_hold;
  logic              pend;
  logic [31:0]       pend_data, st_data;
  logic [ADDR_W+1:0] st_addr, last_wr_addr, m_addr;
  wr_t               m_exp;

  // Avalon slave memory model, evaluated on the falling edge
  always @(negedge clk) begin
    bus.avm_readdatavalid = 1'b0;
    if (reset) begin
      pend = 1'b0;
      stall = 0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata = '0;
    end else begin
      if (pend) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = pend_data;
        pend = 1'b0;
      end
      if (busy !== cpu_hold) hold_err++;
      if (track_hold && !cpu_hold && !done && !error) hold_drop++;
      if (bus.avm_write && bus.avm_read) both_err++;
      if (bus.avm_write || bus.avm_read) begin
        req_cnt++;
        if (stall > 0) begin
          check_eq("stall_addr", 64'(bus.avm_address), 64'(st_addr));
          check_eq("stall_wdata", 64'(bus.avm_writedata), 64'(st_data));
        end else begin
          st_addr = bus.avm_address;
          st_data = bus.avm_writedata;
        end
        if (stall_en && stall < 3) begin
          bus.avm_waitrequest = 1'b1;
          stall++;
        end else begin
          bus.avm_waitrequest = 1'b0;
          stall = 0;
          m_addr = bus.avm_address;
          check_eq("byteenable", 64'(bus.avm_byteenable), 64'hF);
          if (bus.avm_write) begin
            wr_cnt++;
            last_wr_addr = m_addr;
            if (32'(m_addr[ADDR_W+1:2]) < DEPTH) mem[m_addr[ADDR_W+1:2]] = bus.avm_writedata;
            check_eq("wq_nonempty", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
              m_exp = wq.pop_front();
              check_eq("wr_addr", 64'(m_addr), 64'(m_exp.addr));
              check_eq("wr_data", 64'(bus.avm_writedata), 64'(m_exp.data));
            end
            rq.push_back(m_addr);
          end else begin
            rd_cnt++;
            check_eq("rq_nonempty", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) check_eq("rd_addr", 64'(m_addr), 64'(rq.pop_front()));
            pend = 1'b1;
            pend_data = (32'(m_addr[ADDR_W+1:2]) < DEPTH) ? mem[m_addr[ADDR_W+1:2]] : 32'h0;
            if (corrupt_en && m_addr == (ADDR_W+2)'(8)) pend_data = pend_data + 32'd1;
          end
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
        stall = 0;
      end
    end
  end

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; req_cnt = 0; both_err = 0; hold_err = 0; hold_drop = 0;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    word_count = ADDR_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed src into the stream; gap idle cycles before each word
  task automatic send_words(input int gap);
    int t;
    for (int i = 0; i < src.size(); i++) begin
      repeat (gap) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
      end
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = src[i];
      wq.push_back('{addr: (ADDR_W+2)'(i << 2), data: src[i]});
      t = 0;
      while (!bus.s_ready && t < 64) begin
        @(negedge clk);
        t++;
      end
      check_eq("s_ready", 64'(bus.s_ready), 64'd1);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input int gap, input logic exp_done, input int budget);
    logic [31:0] sum;
    int t;
    sum = '0;
    foreach (src[i]) sum = sum + src[i];
    clear_counts();
    do_start(src.size());
    check_eq({tag, "_busy_start"}, 64'(busy), 64'd1);
    check_eq({tag, "_done_clr"}, 64'(done), 64'd0);
    check_eq({tag, "_sum_clr"}, 64'(checksum), 64'd0);
    track_hold = 1'b1;
    send_words(gap);
    t = 0;
    while (!(done || error) && t < budget) begin
      @(negedge clk);
      t++;
    end
    track_hold = 1'b0;
    check_eq({tag, "_finished"}, 64'(done || error), 64'd1);
    check_eq({tag, "_done"}, 64'(done), 64'(exp_done));
    check_eq({tag, "_error"}, 64'(error), 64'(!exp_done));
    check_eq({tag, "_checksum"}, 64'(checksum), 64'(sum));
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
    check_eq({tag, "_writes"}, 64'(wr_cnt), 64'(src.size()));
    check_eq({tag, "_reads"}, 64'(rd_cnt), 64'(src.size()));
    check_eq({tag, "_wr_rd_overlap"}, 64'(both_err), 64'd0);
    check_eq({tag, "_hold_eq_busy"}, 64'(hold_err), 64'd0);
    check_eq({tag, "_hold_drop"}, 64'(hold_drop), 64'd0);
    check_eq({tag, "_queues_empty"}, 64'(wq.size() + rq.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_error"}, 64'(error), 64'd0);
    check_eq({tag, "_checksum"}, 64'(checksum), 64'd0);
    check_eq({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    check_eq({tag, "_write"}, 64'(bus.avm_write), 64'd0);
    check_eq({tag, "_read"}, 64'(bus.avm_read), 64'd0);
    check_eq({tag, "_address"}, 64'(bus.avm_address), 64'd0);
    check_eq({tag, "_wdata"}, 64'(bus.avm_writedata), 64'd0);
    check_eq({tag, "_byteenable"}, 64'(bus.avm_byteenable), 64'hF);
  endtask

  initial begin
    int t;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    stall_en = 1'b0;
    corrupt_en = 1'b0;
    track_hold = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // 1: basic 4-word load, no stalls
    src = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_load("t1", 0, 1'b1, 200);
    check_eq("t1_checksum_const", 64'(checksum), 64'hAAAAAAAA);

    // 2: every write and read stalled three cycles
    stall_en = 1'b1;
    run_load("t2", 0, 1'b1, 400);
    stall_en = 1'b0;

    // 3: corrupted readback at byte address 0x8
    corrupt_en = 1'b1;
    run_load("t3", 0, 1'b0, 200);
    check_eq("t3_checksum_const", 64'(checksum), 64'hAAAAAAAA);
    corrupt_en = 1'b0;

    // 4: illegal counts fail immediately with no bus activity
    clear_counts();
    do_start(0);
    check_eq("t4_zero_error", 64'(error), 64'd1);
    check_eq("t4_zero_busy", 64'(busy), 64'd0);
    check_eq("t4_zero_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("t4_zero_busy_later", 64'(busy), 64'd0);
    do_start(DEPTH + 1);
    check_eq("t4_big_error", 64'(error), 64'd1);
    check_eq("t4_big_busy", 64'(busy), 64'd0);
    check_eq("t4_big_sum", 64'(checksum), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("t4_big_busy_later", 64'(busy), 64'd0);
    check_eq("t4_no_requests", 64'(req_cnt), 64'd0);

    // 5: reset after the second write, then a fresh load
    clear_counts();
    src = '{32'h11111111, 32'h22222222};
    do_start(4);
    send_words(0);
    t = 0;
    while (wr_cnt < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("t5_two_writes", 64'(wr_cnt), 64'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_reset");
    reset = 1'b0;
    wq.delete();
    rq.delete();
    src = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_load("t5_reload", 0, 1'b1, 200);

    // 6: full-depth load with a gapped stream
    src.delete();
    for (int i = 0; i < int'(DEPTH); i++) src.push_back($urandom);
    run_load("t6", 2, 1'b1, 40000);
    check_eq("t6_last_addr", 64'(last_wr_addr), 64'h4FFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected end of run", $time);
    $fatal(1, "timeout");
  end
endmodule
